fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the instruction memory.
- Owns the 4-bit program counter that drives the memory's PC input.
- Captures the 9-bit instruction returned combinationally into an instruction register for the decode stage.
- Handles sequential increment, taken branches with a one-slot squash, stall, and halt.

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures the combinational
// instruction word into IR, and handles branch squash, stall and halt.
module fetch_unit #(
    parameter int              PC_W     = 4,
    parameter int              INS_W    = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             STALL,
    input  logic             BR_TAKEN,
    input  logic [PC_W-1:0]  BR_TARGET,
    input  logic             HALT_REQ,
    input  logic [INS_W-1:0] INS_IN,
    output logic [PC_W-1:0]  PC,
    output logic [INS_W-1:0] IR,
    output logic [PC_W-1:0]  IR_PC,
    output logic             IR_VALID,
    output logic             HALTED,
    output logic             WRAP
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [PC_W-1:0]  pc, pc_n;
    logic [INS_W-1:0] ir, ir_n;
    logic [PC_W-1:0]  ir_pc, ir_pc_n;
    logic             ir_valid, ir_valid_n;
    logic             wrap, wrap_n;

    // One-hot decode of the FETCH priority chain
    logic do_halt;
    logic do_br;
    logic do_hold;
    logic do_fetch;

    assign do_halt  = HALT_REQ;
    assign do_br    = !HALT_REQ && BR_TAKEN;
    assign do_hold  = !HALT_REQ && !BR_TAKEN && (STALL || !EN);
    assign do_fetch = !HALT_REQ && !BR_TAKEN && !STALL && EN;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_pc    <= ir_pc_n;
            ir_valid <= ir_valid_n;
            wrap     <= wrap_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        ir_pc_n    = ir_pc;
        ir_valid_n = ir_valid;
        wrap_n     = 1'b0;
        unique case (state)
            IDLE: begin
                pc_n       = RESET_PC;
                ir_valid_n = 1'b0;
                if (HALT_REQ) begin
                    state_n = HALT;
                end else if (EN) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                unique case (1'b1)
                    do_halt: begin
                        state_n    = HALT;
                        ir_valid_n = 1'b0;
                    end
                    do_br: begin
                        // Word at the current PC is squashed
                        pc_n       = BR_TARGET;
                        ir_valid_n = 1'b0;
                    end
                    do_hold: begin
                        pc_n = pc;
                    end
                    do_fetch: begin
                        ir_n       = INS_IN;
                        ir_pc_n    = pc;
                        ir_valid_n = 1'b1;
                        pc_n       = pc + 1'b1;
                        wrap_n     = (pc == '1);
                    end
                    default: begin
                        pc_n = pc;
                    end
                endcase
            end
            HALT: begin
                ir_valid_n = 1'b0;
            end
            default: begin
                state_n    = IDLE;
                pc_n       = RESET_PC;
                ir_valid_n = 1'b0;
            end
        endcase
    end

    assign PC       = pc;
    assign IR       = ir;
    assign IR_PC    = ir_pc;
    assign IR_VALID = ir_valid;
    assign HALTED   = (state == HALT);
    assign WRAP     = wrap;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected IR words are queued when a
// fetch edge is driven and compared when the capture appears.
module tb_fetch_unit;

    logic       CLK;
    logic       RST_N;
    logic       EN;
    logic       STALL;
    logic       BR_TAKEN;
    logic [3:0] BR_TARGET;
    logic       HALT_REQ;
    logic [8:0] INS_IN;
    logic [3:0] PC;
    logic [8:0] IR;
    logic [3:0] IR_PC;
    logic       IR_VALID;
    logic       HALTED;
    logic       WRAP;

    typedef struct {
        logic [8:0] ir;
        logic [3:0] pc;
    } exp_t;

    exp_t sbq[$];
    int   total;
    int   passed;

    fetch_unit #(.PC_W(4), .INS_W(9), .RESET_PC(4'h0)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .EN(EN),
        .STALL(STALL),
        .BR_TAKEN(BR_TAKEN),
        .BR_TARGET(BR_TARGET),
        .HALT_REQ(HALT_REQ),
        .INS_IN(INS_IN),
        .PC(PC),
        .IR(IR),
        .IR_PC(IR_PC),
        .IR_VALID(IR_VALID),
        .HALTED(HALTED),
        .WRAP(WRAP)
    );

    function automatic logic [8:0] ins(input logic [3:0] a);
        logic [8:0] t;
        t = {5'd0, a} * 9'd7 + 9'd3;
        return t ^ 9'h0A5;
    endfunction

    // Linear instruction memory
    assign INS_IN = ins(PC);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        EN = 1'b0;
        STALL = 1'b0;
        BR_TAKEN = 1'b0;
        BR_TARGET = 4'h0;
        HALT_REQ = 1'b0;
        #1;
        total++;
        if (PC !== 4'h0 || IR !== 9'h0 || IR_PC !== 4'h0) begin
            $display("FAIL reset_regs pc=%h ir=%h ir_pc=%h want 0/0/0", PC, IR, IR_PC);
        end else passed++;
        total++;
        if (IR_VALID !== 1'b0 || HALTED !== 1'b0 || WRAP !== 1'b0) begin
            $display("FAIL reset_flags v=%b h=%b w=%b want 000", IR_VALID, HALTED, WRAP);
        end else passed++;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        total++;
        if (PC !== 4'h0 || IR_VALID !== 1'b0) begin
            $display("FAIL idle_hold pc=%h v=%b want 0/0", PC, IR_VALID);
        end else passed++;
    endtask

    task automatic test_linear();
        exp_t e;
        EN = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i >= 2) sbq.push_back('{ins(4'(i - 2)), 4'(i - 2)});
            tick();
            total++;
            if (PC !== 4'(i - 1)) begin
                $display("FAIL linear_pc got %h want %h", PC, 4'(i - 1));
            end else passed++;
            total++;
            if (IR_VALID !== (i >= 2)) begin
                $display("FAIL linear_valid edge %0d got %b", i, IR_VALID);
            end else passed++;
            if (i >= 2) begin
                total++;
                if (sbq.size() == 0) begin
                    $display("FAIL linear_sb queue empty got nothing want entry");
                end else begin
                    e = sbq.pop_front();
                    if (IR !== e.ir || IR_PC !== e.pc) begin
                        $display("FAIL linear_ir got %h@%h want %h@%h", IR, IR_PC, e.ir, e.pc);
                    end else passed++;
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t       e;
        logic [3:0] xp[3];
        logic       xw[3];
        xp = '{4'd15, 4'd0, 4'd1};
        xw = '{1'b0, 1'b1, 1'b0};
        BR_TAKEN = 1'b1;
        BR_TARGET = 4'h0;
        tick();
        total++;
        if (PC !== 4'h0 || WRAP !== 1'b0) begin
            $display("FAIL br_to_zero pc=%h wrap=%b want 0/0", PC, WRAP);
        end else passed++;
        BR_TARGET = 4'hE;
        tick();
        BR_TAKEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sbq.push_back('{ins(4'(14 + i)), 4'(14 + i)});
            tick();
            total++;
            if (PC !== xp[i] || WRAP !== xw[i]) begin
                $display("FAIL wrap pc=%h w=%b want %h/%b", PC, WRAP, xp[i], xw[i]);
            end else passed++;
            total++;
            if (sbq.size() == 0) begin
                $display("FAIL wrap_sb queue empty got nothing want entry");
            end else begin
                e = sbq.pop_front();
                if (IR !== e.ir || IR_PC !== e.pc) begin
                    $display("FAIL wrap_ir got %h@%h want %h@%h", IR, IR_PC, e.ir, e.pc);
                end else passed++;
            end
        end
    endtask

    task automatic test_branch();
        exp_t e;
        BR_TAKEN = 1'b1;
        BR_TARGET = 4'h5;
        tick();
        BR_TARGET = 4'h2;
        tick();
        BR_TAKEN = 1'b0;
        total++;
        if (PC !== 4'h2 || IR_VALID !== 1'b0) begin
            $display("FAIL branch_squash pc=%h v=%b want 2/0", PC, IR_VALID);
        end else passed++;
        for (int i = 2; i <= 3; i++) begin
            sbq.push_back('{ins(4'(i)), 4'(i)});
            tick();
            total++;
            if (PC !== 4'(i + 1) || IR_VALID !== 1'b1) begin
                $display("FAIL branch_resume pc=%h v=%b want %h/1", PC, IR_VALID, 4'(i + 1));
            end else passed++;
            total++;
            if (sbq.size() == 0) begin
                $display("FAIL branch_sb queue empty got nothing want entry");
            end else begin
                e = sbq.pop_front();
                if (IR !== e.ir || IR_PC !== e.pc) begin
                    $display("FAIL branch_ir got %h@%h want %h@%h", IR, IR_PC, e.ir, e.pc);
                end else passed++;
            end
            if (i == 2) begin
                BR_TAKEN = 1'b1;
                BR_TARGET = 4'h3;
                tick();
                BR_TAKEN = 1'b0;
                total++;
                if (PC !== 4'h3 || IR_VALID !== 1'b0) begin
                    $display("FAIL branch_self pc=%h v=%b want 3/0", PC, IR_VALID);
                end else passed++;
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        BR_TAKEN = 1'b1;
        BR_TARGET = 4'h6;
        tick();
        BR_TAKEN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sbq.push_back('{ins(4'(6 + i)), 4'(6 + i)});
            tick();
            total++;
            if (PC !== 4'(7 + i)) begin
                $display("FAIL stall_pc got %h want %h", PC, 4'(7 + i));
            end else passed++;
            total++;
            if (sbq.size() == 0) begin
                $display("FAIL stall_sb queue empty got nothing want entry");
            end else begin
                e = sbq.pop_front();
                if (IR !== e.ir || IR_PC !== e.pc) begin
                    $display("FAIL stall_ir got %h@%h want %h@%h", IR, IR_PC, e.ir, e.pc);
                end else passed++;
            end
            if (i == 0) begin
                STALL = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    total++;
                    if (PC !== 4'h7 || IR !== ins(4'h6) || IR_VALID !== 1'b1) begin
                        $display("FAIL stall_hold pc=%h ir=%h v=%b want 7/%h/1", PC, IR, IR_VALID, ins(4'h6));
                    end else passed++;
                end
                STALL = 1'b0;
            end
        end
        EN = 1'b0;
        tick();
        EN = 1'b1;
        total++;
        if (PC !== 4'h8 || IR !== ins(4'h7) || IR_VALID !== 1'b1) begin
            $display("FAIL en_low_hold pc=%h ir=%h v=%b want 8/%h/1", PC, IR, IR_VALID, ins(4'h7));
        end else passed++;
    endtask

    task automatic test_branch_stall();
        exp_t e;
        STALL = 1'b1;
        BR_TAKEN = 1'b1;
        BR_TARGET = 4'hC;
        tick();
        BR_TAKEN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (PC !== 4'hC || IR_VALID !== 1'b0) begin
                $display("FAIL br_stall pc=%h v=%b want c/0", PC, IR_VALID);
            end else passed++;
            if (k < 2) tick();
        end
        STALL = 1'b0;
        sbq.push_back('{ins(4'hC), 4'hC});
        tick();
        total++;
        if (PC !== 4'hD || IR_VALID !== 1'b1) begin
            $display("FAIL br_stall_rel pc=%h v=%b want d/1", PC, IR_VALID);
        end else passed++;
        total++;
        if (sbq.size() == 0) begin
            $display("FAIL br_stall_sb queue empty got nothing want entry");
        end else begin
            e = sbq.pop_front();
            if (IR !== e.ir || IR_PC !== e.pc) begin
                $display("FAIL br_stall_ir got %h@%h want %h@%h", IR, IR_PC, e.ir, e.pc);
            end else passed++;
        end
    endtask

    task automatic test_halt();
        exp_t e;
        BR_TAKEN = 1'b1;
        BR_TARGET = 4'h9;
        tick();
        BR_TAKEN = 1'b0;
        HALT_REQ = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (HALTED !== 1'b1 || PC !== 4'h9 || IR_VALID !== 1'b0) begin
                $display("FAIL halt h=%b pc=%h v=%b want 1/9/0", HALTED, PC, IR_VALID);
            end else passed++;
            EN = i[0];
            STALL = i[1];
            BR_TAKEN = 1'b1;
            BR_TARGET = 4'(i);
            if (i < 4) tick();
        end
        #3;
        RST_N = 1'b0;
        #1;
        total++;
        if (PC !== 4'h0 || HALTED !== 1'b0 || IR_VALID !== 1'b0 || WRAP !== 1'b0) begin
            $display("FAIL async_rst pc=%h h=%b v=%b w=%b want 0/0/0/0", PC, HALTED, IR_VALID, WRAP);
        end else passed++;
        #1;
        RST_N = 1'b1;
        BR_TAKEN = 1'b0;
        STALL = 1'b0;
        EN = 1'b0;
        tick();
        total++;
        if (PC !== 4'h0 || IR_VALID !== 1'b0 || HALTED !== 1'b0) begin
            $display("FAIL post_rst_idle pc=%h v=%b h=%b want 0/0/0", PC, IR_VALID, HALTED);
        end else passed++;
        HALT_REQ = 1'b1;
        EN = 1'b1;
        tick();
        HALT_REQ = 1'b0;
        total++;
        if (HALTED !== 1'b1 || PC !== 4'h0) begin
            $display("FAIL idle_halt h=%b pc=%h want 1/0", HALTED, PC);
        end else passed++;
        tick();
        RST_N = 1'b0;
        #1;
        RST_N = 1'b1;
        tick();
        sbq.push_back('{ins(4'h0), 4'h0});
        tick();
        total++;
        if (sbq.size() == 0) begin
            $display("FAIL restart_sb queue empty got nothing want entry");
        end else begin
            e = sbq.pop_front();
            if (IR !== e.ir || IR_PC !== e.pc || IR_VALID !== 1'b1 || PC !== 4'h1) begin
                $display("FAIL restart got %h@%h v=%b pc=%h want %h@%h v=1 pc=1", IR, IR_PC, IR_VALID, PC, e.ir, e.pc);
            end else passed++;
        end
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_linear();
        test_wrap();
        test_branch();
        test_stall();
        test_branch_stall();
        test_halt();
        total++;
        if (sbq.size() != 0) begin
            $display("FAIL sb_drain got %0d left want 0", sbq.size());
        end else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
